// File: rtl/differentiator_comb.sv
// Saturating comb differentiator: y[n] = x[n] - x[n-DELAY] on a valid-qualified stream.
// Define DIFF_COMB_SAT_EN to clamp the difference; otherwise it wraps and sat_o stays 0.
module differentiator_comb #(
  parameter int WIDTH = 10,
  parameter int DELAY = 1
) (
  input  logic                    system1000,
  input  logic                    system1000_rst,
  input  logic                    clear_i,
  input  logic                    vld_i,
  input  logic signed [WIDTH-1:0] x_i,
  output logic                    vld_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic                    sat_o
);

  // Handshake: the block is always ready. A sample is accepted on any rising edge
  // where vld_i=1 and reset is low. Its result appears one edge later with a
  // single-cycle vld_o pulse. y_o/sat_o hold their values while vld_o=0.

  logic signed [WIDTH-1:0] r_hist [DELAY];
  logic signed [WIDTH-1:0] w_oldest;
  logic signed [WIDTH-1:0] w_y;
  logic                    w_sat;

  // A clear in the same cycle as a sample makes the delayed operand zero.
  assign w_oldest = clear_i ? '0 : r_hist[DELAY-1];

`ifdef DIFF_COMB_SAT_EN
  logic signed [WIDTH:0] w_diff;
  logic                  w_ovf;

  assign w_diff = {x_i[WIDTH-1], x_i} - {w_oldest[WIDTH-1], w_oldest};
  assign w_ovf  = w_diff[WIDTH] ^ w_diff[WIDTH-1];

  always_comb begin
    w_y   = w_diff[WIDTH-1:0];
    w_sat = 1'b0;
    if (w_ovf) begin
      w_sat = 1'b1;
      w_y   = x_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_y   = x_i - w_oldest;
  assign w_sat = 1'b0;
`endif

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      for (int i = 0; i < DELAY; i++) r_hist[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < DELAY; i++) r_hist[i] <= '0;
      if (vld_i) r_hist[0] <= x_i;
    end else if (vld_i) begin
      r_hist[0] <= x_i;
      for (int i = 1; i < DELAY; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      vld_o <= 1'b0;
      y_o   <= '0;
      sat_o <= 1'b0;
    end else begin
      vld_o <= vld_i;
      if (vld_i) begin
        y_o   <= w_y;
        sat_o <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_differentiator_comb.sv
// Bench for differentiator_comb: three instances (DELAY=1,2,3) share one input stream
// and are checked against a queue-based model of accepted samples.
module tb_differentiator_comb;

  localparam int W  = 10;
  localparam int HI = 511;
  localparam int LO = -512;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic                clr = 1'b0;
  logic                vld = 1'b0;
  logic signed [W-1:0] x   = '0;

  logic                vld_a [3];
  logic signed [W-1:0] y_a   [3];
  logic                sat_a [3];

  differentiator_comb #(.WIDTH(W), .DELAY(1)) u_d1 (
    .system1000(clk), .system1000_rst(rst), .clear_i(clr), .vld_i(vld), .x_i(x),
    .vld_o(vld_a[0]), .y_o(y_a[0]), .sat_o(sat_a[0]));
  differentiator_comb #(.WIDTH(W), .DELAY(2)) u_d2 (
    .system1000(clk), .system1000_rst(rst), .clear_i(clr), .vld_i(vld), .x_i(x),
    .vld_o(vld_a[1]), .y_o(y_a[1]), .sat_o(sat_a[1]));
  differentiator_comb #(.WIDTH(W), .DELAY(3)) u_d3 (
    .system1000(clk), .system1000_rst(rst), .clear_i(clr), .vld_i(vld), .x_i(x),
    .vld_o(vld_a[2]), .y_o(y_a[2]), .sat_o(sat_a[2]));

  // reference model: accepted samples since the last reset/clear, newest at back
  int                  acc_q[$];
  logic                exp_vld;
  logic signed [W-1:0] exp_y   [3];
  logic                exp_sat [3];

  int test_cnt = 0;
  int fail_cnt = 0;

  task automatic model_step(input logic r, input logic c, input logic v, input int xv);
    int old, d;
    if (r) begin
      acc_q.delete();
      exp_vld = 1'b0;
      for (int k = 0; k < 3; k++) begin
        exp_y[k]   = '0;
        exp_sat[k] = 1'b0;
      end
    end else begin
      exp_vld = v;
      if (c) acc_q.delete();
      if (v) begin
        for (int k = 0; k < 3; k++) begin
          old = (acc_q.size() >= k + 1) ? acc_q[acc_q.size() - (k + 1)] : 0;
          d   = xv - old;
          exp_sat[k] = 1'b0;
`ifdef DIFF_COMB_SAT_EN
          if (d > HI) begin
            d = HI; exp_sat[k] = 1'b1;
          end else if (d < LO) begin
            d = LO; exp_sat[k] = 1'b1;
          end
`endif
          exp_y[k] = W'(d);
        end
        acc_q.push_back(xv);
        if (acc_q.size() > 16) void'(acc_q.pop_front());
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      test_cnt++;
      assert (vld_a[k] === exp_vld) else begin
        fail_cnt++;
        $error("FAIL %s vld_d%0d got=%0b exp=%0b", tag, k + 1, vld_a[k], exp_vld);
      end
      test_cnt++;
      assert (y_a[k] === exp_y[k]) else begin
        fail_cnt++;
        $error("FAIL %s y_d%0d got=%0d exp=%0d", tag, k + 1, y_a[k], exp_y[k]);
      end
      test_cnt++;
      assert (sat_a[k] === exp_sat[k]) else begin
        fail_cnt++;
        $error("FAIL %s sat_d%0d got=%0b exp=%0b", tag, k + 1, sat_a[k], exp_sat[k]);
      end
    end
  endtask

  // driver: present inputs, clock once, then compare away from the edge
  task automatic step(input string tag, input logic r, input logic c, input logic v, input int xv);
    rst = r; clr = c; vld = v; x = W'(xv);
    model_step(r, c, v, xv);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic direct_y(input string tag, input int k, input int yv);
    logic signed [W-1:0] want;
    want = W'(yv);
    test_cnt++;
    assert (y_a[k] === want) else begin
      fail_cnt++;
      $error("FAIL %s got=%0d exp=%0d", tag, y_a[k], want);
    end
  endtask

  initial begin
    int xv;
    logic r, c, v;

    // reset state
    step("reset", 1'b1, 1'b0, 1'b0, 0);
    step("reset2", 1'b1, 1'b0, 1'b0, 0);

    // ramp, D=1: 5,7,12 -> 5,2,5
    step("ramp0", 1'b0, 1'b0, 1'b1, 5);   direct_y("ramp_y0", 0, 5);
    step("ramp1", 1'b0, 1'b0, 1'b1, 7);   direct_y("ramp_y1", 0, 2);
    step("ramp2", 1'b0, 1'b0, 1'b1, 12);  direct_y("ramp_y2", 0, 5);
    step("ramp_idle", 1'b0, 1'b0, 1'b0, 0);

    // positive and negative clamp, D=1
    step("pclr", 1'b0, 1'b1, 1'b0, 0);
    step("pc0", 1'b0, 1'b0, 1'b1, -512);
    step("pc1", 1'b0, 1'b0, 1'b1, 511);
`ifdef DIFF_COMB_SAT_EN
    direct_y("pclamp_y", 0, 511);
`else
    direct_y("pwrap_y", 0, -1);
`endif
    step("nclr", 1'b0, 1'b1, 1'b0, 0);
    step("nc0", 1'b0, 1'b0, 1'b1, 511);
    step("nc1", 1'b0, 1'b0, 1'b1, -512);
`ifdef DIFF_COMB_SAT_EN
    direct_y("nclamp_y", 0, -512);
`else
    direct_y("nwrap_y", 0, 1);
`endif

    // gapped stream, D=3: 10,20,30,40 -> 10,20,30,30
    step("gclr", 1'b0, 1'b1, 1'b0, 0);
    step("g0", 1'b0, 1'b0, 1'b1, 10);  direct_y("gap_y0", 2, 10);
    step("gi0", 1'b0, 1'b0, 1'b0, 0);
    step("gi1", 1'b0, 1'b0, 1'b0, 0);
    step("g1", 1'b0, 1'b0, 1'b1, 20);  direct_y("gap_y1", 2, 20);
    step("gi2", 1'b0, 1'b0, 1'b0, 0);
    step("g2", 1'b0, 1'b0, 1'b1, 30);  direct_y("gap_y2", 2, 30);
    step("gi3", 1'b0, 1'b0, 1'b0, 0);  direct_y("gap_hold", 2, 30);
    step("g3", 1'b0, 1'b0, 1'b1, 40);  direct_y("gap_y3", 2, 30);

    // clear with sample, D=2: 100,200,clear+50,60 -> 100,200,50,60
    step("cclr", 1'b0, 1'b1, 1'b0, 0);
    step("c0", 1'b0, 1'b0, 1'b1, 100);  direct_y("cs_y0", 1, 100);
    step("c1", 1'b0, 1'b0, 1'b1, 200);  direct_y("cs_y1", 1, 200);
    step("c2", 1'b0, 1'b1, 1'b1, 50);   direct_y("cs_y2", 1, 50);
    step("c3", 1'b0, 1'b0, 1'b1, 60);   direct_y("cs_y3", 1, 60);

    // reset mid-stream, D=2: 8,9,reset with sample,3 -> 3
    step("r0", 1'b0, 1'b0, 1'b1, 8);
    step("r1", 1'b0, 1'b0, 1'b1, 9);
    step("rmid", 1'b1, 1'b0, 1'b1, 77);  direct_y("rst_y0", 1, 0);
    step("r2", 1'b0, 1'b0, 1'b1, 3);     direct_y("rst_y3", 1, 3);

    // randomized stream
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 29) == 0);
      v = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 5))
        0:       xv = HI;
        1:       xv = LO;
        default: xv = int'($urandom_range(0, 1023)) - 512;
      endcase
      step("rand", r, c, v, xv);
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
